// File: rtl/collatz_pkg.sv
// Shared constants for the collatz Wishbone bridge: register map, STATUS/CTRL
// bit positions and the run-control state encoding.
package collatz_pkg;

    localparam int WIDTH = 16;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_STEPS  = 2'd2;
    localparam logic [1:0] REG_PEAK   = 2'd3;

    localparam int CTRL_GO_BIT     = 16;
    localparam int CTRL_IRQ_EN_BIT = 17;

    localparam int ST_BUSY_BIT  = 16;
    localparam int ST_DONE_BIT  = 17;
    localparam int ST_ERR_BIT   = 18;
    localparam int ST_STATE_LSB = 19;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RUN    = 2'd3
    } state_e;

endpackage

// File: rtl/collatz_run_monitor.sv
// Observes the core value while a run is active: counts value changes
// (saturating) and tracks the largest value seen, starting from the seed.
module collatz_run_monitor
    import collatz_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] seed,
    input  logic [W-1:0] x,
    output logic [31:0]  steps,
    output logic [W-1:0] peak
);

    logic [W-1:0] prev_r;
    logic [31:0]  steps_r;
    logic [W-1:0] peak_r;

    // Previous-value history, step counter and peak tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r  <= {W{1'b0}};
            steps_r <= 32'd0;
            peak_r  <= {W{1'b0}};
        end else begin
            prev_r <= x;
            if (clear) begin
                steps_r <= 32'd0;
                peak_r  <= seed;
            end else if (enable && (x != prev_r)) begin
                if (steps_r != 32'hFFFF_FFFF) begin
                    steps_r <= steps_r + 32'd1;
                end
                if (x > peak_r) begin
                    peak_r <= x;
                end
            end
        end
    end

    assign steps = steps_r;
    assign peak  = peak_r;

endmodule

// File: rtl/collatz_wb_bridge.sv
// Wishbone classic slave that launches the collatz core, records the run
// statistics and raises a completion interrupt.
module collatz_wb_bridge
    import collatz_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter int          WIDTH         = collatz_pkg::WIDTH,
    parameter int          START_TIMEOUT = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic             irq_o,
    output logic             core_st_o,
    output logic [WIDTH-1:0] core_co_o,
    input  logic [WIDTH-1:0] core_x_i,
    input  logic             core_bs_i
);

    state_e            state_r, state_nx;
    logic [WIDTH-1:0]  seed_r;
    logic              irq_en_r, done_r, err_r;
    logic [7:0]        tmo_r;
    logic              hit_s, acc_s, wr_s, ctrl_wr_s, status_wr_s, go_s;
    logic              launch_s, go_err_s, tmo_s, done_set_s;
    logic [1:0]        reg_sel_s;
    logic [31:0]       rdata_s, steps_s;
    logic [WIDTH-1:0]  peak_s;
    logic              unused_s;

    assign hit_s       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign acc_s       = hit_s & ~wbs_ack_o;
    assign wr_s        = acc_s & wbs_we_i & (wbs_sel_i == 4'hF);
    assign reg_sel_s   = wbs_adr_i[3:2];
    assign ctrl_wr_s   = wr_s & (reg_sel_s == REG_CTRL);
    assign status_wr_s = wr_s & (reg_sel_s == REG_STATUS);
    assign go_s        = ctrl_wr_s & wbs_dat_i[CTRL_GO_BIT];
    assign unused_s    = &{1'b0, wbs_adr_i[1:0], wbs_dat_i[31:19]};

    // Run-control state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next state plus launch / error / completion strobes; go outside IDLE is an error.
    always_comb begin
        state_nx   = state_r;
        launch_s   = 1'b0;
        go_err_s   = 1'b0;
        tmo_s      = 1'b0;
        done_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (go_s) begin
                    if (!core_bs_i && (wbs_dat_i[WIDTH-1:0] != {WIDTH{1'b0}})) begin
                        launch_s = 1'b1;
                        state_nx = LAUNCH;
                    end else begin
                        go_err_s = 1'b1;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            LAUNCH: begin
                go_err_s = go_s;
                state_nx = WAIT;
            end
            WAIT: begin
                go_err_s = go_s;
                if (core_bs_i) begin
                    state_nx = RUN;
                end else if (tmo_r == 8'(START_TIMEOUT - 1)) begin
                    tmo_s    = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = WAIT;
                end
            end
            RUN: begin
                go_err_s = go_s;
                if (!core_bs_i) begin
                    done_set_s = 1'b1;
                    state_nx   = IDLE;
                end else begin
                    state_nx = RUN;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Register read multiplexer.
    always_comb begin
        rdata_s = 32'h0;
        case (reg_sel_s)
            REG_CTRL: begin
                rdata_s[WIDTH-1:0]      = seed_r;
                rdata_s[CTRL_IRQ_EN_BIT] = irq_en_r;
            end
            REG_STATUS: begin
                rdata_s[WIDTH-1:0]          = core_x_i;
                rdata_s[ST_BUSY_BIT]        = core_bs_i;
                rdata_s[ST_DONE_BIT]        = done_r;
                rdata_s[ST_ERR_BIT]         = err_r;
                rdata_s[ST_STATE_LSB +: 2]  = state_r;
            end
            REG_STEPS: begin
                rdata_s = steps_s;
            end
            REG_PEAK: begin
                rdata_s[WIDTH-1:0] = peak_s;
            end
            default: begin
                rdata_s = 32'h0;
            end
        endcase
    end

    // Bus response, control/status registers, core handshake and interrupt.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0;
            irq_o     <= 1'b0;
            core_st_o <= 1'b0;
            core_co_o <= {WIDTH{1'b0}};
            seed_r    <= {WIDTH{1'b0}};
            irq_en_r  <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            tmo_r     <= 8'd0;
        end else begin
            wbs_ack_o <= acc_s;
            wbs_dat_o <= (acc_s && !wbs_we_i) ? rdata_s : 32'h0;
            core_st_o <= (state_nx == LAUNCH);
            irq_o     <= done_r & irq_en_r;
            tmo_r     <= (state_r == WAIT) ? (tmo_r + 8'd1) : 8'd0;
            if (launch_s) begin
                core_co_o <= wbs_dat_i[WIDTH-1:0];
            end
            if (ctrl_wr_s) begin
                irq_en_r <= wbs_dat_i[CTRL_IRQ_EN_BIT];
                if (state_r == IDLE) begin
                    seed_r <= wbs_dat_i[WIDTH-1:0];
                end
            end
            if (done_set_s) begin
                done_r <= 1'b1;
            end else if (launch_s || (status_wr_s && wbs_dat_i[ST_DONE_BIT])) begin
                done_r <= 1'b0;
            end
            if (go_err_s || tmo_s) begin
                err_r <= 1'b1;
            end else if (status_wr_s && wbs_dat_i[ST_ERR_BIT]) begin
                err_r <= 1'b0;
            end
        end
    end

    collatz_run_monitor #(.W(WIDTH)) u_monitor (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clear  (launch_s),
        .enable (state_r == RUN),
        .seed   (wbs_dat_i[WIDTH-1:0]),
        .x      (core_x_i),
        .steps  (steps_s),
        .peak   (peak_s)
    );

endmodule

// File: tb/tb_collatz_wb_bridge.sv
// Directed bench for collatz_wb_bridge with a behavioural collatz core model.
module tb_collatz_wb_bridge;

    localparam logic [31:0] A_CTRL   = 32'h3000_0000;
    localparam logic [31:0] A_STATUS = 32'h3000_0004;
    localparam logic [31:0] A_STEPS  = 32'h3000_0008;
    localparam logic [31:0] A_PEAK   = 32'h3000_000C;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [15:0] seed;
        logic [31:0] steps;
        logic [15:0] peak;
    } run_vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w;
    logic        ack;
    logic [31:0] dat_r;
    logic        irq, core_st;
    logic [15:0] core_co;
    logic [15:0] x_m;
    logic        bs_m, force_bs, model_en, model_rst;
    logic        core_bs;
    logic [31:0] st_cnt;
    logic [15:0] co_cap;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign core_bs = bs_m | force_bs;

    collatz_wb_bridge dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat_w),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_r),
        .irq_o     (irq),
        .core_st_o (core_st),
        .core_co_o (core_co),
        .core_x_i  (x_m),
        .core_bs_i (core_bs)
    );

    // Behavioural collatz core: loads on start, one step per cycle, busy drops after reaching 1.
    always @(posedge clk) begin
        if (model_rst) begin
            x_m  <= 16'd0;
            bs_m <= 1'b0;
        end else if (core_st && model_en) begin
            x_m  <= core_co;
            bs_m <= 1'b1;
        end else if (bs_m) begin
            if (x_m == 16'd1) bs_m <= 1'b0;
            else if (x_m[0]) x_m <= 16'(3 * x_m + 16'd1);
            else x_m <= x_m >> 1;
        end
    end

    // Start pulse counter and seed capture.
    always @(posedge clk) begin
        if (model_rst) begin
            st_cnt <= 32'd0;
            co_cap <= 16'd0;
        end else if (core_st) begin
            st_cnt <= st_cnt + 32'd1;
            co_cap <= core_co;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output int lat);
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        lat = 0;
        rd  = 32'h0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                lat = i;
                rd  = dat_r;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        int lat;
        wb_xfer(a, 1'b1, d, 4'hF, rd, lat);
        chk("wr_ack_latency", 32'(lat), 32'd1);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        int lat;
        wb_xfer(a, 1'b0, 32'h0, 4'hF, d, lat);
        chk("rd_ack_latency", 32'(lat), 32'd1);
    endtask

    task automatic do_run(input logic [15:0] seed, input logic [31:0] exp_steps,
                          input logic [15:0] exp_peak);
        logic [31:0] d, s0;
        logic found;
        int lat;
        s0 = st_cnt;
        found = 1'b0;
        wb_write(A_CTRL, {14'd0, 2'b11, seed});
        for (int i = 0; i < 300; i++) begin
            wb_xfer(A_STATUS, 1'b0, 32'h0, 4'hF, d, lat);
            if (lat == 1 && d[17]) begin
                found = 1'b1;
                break;
            end
        end
        chk("run_done_seen", 32'(found), 32'd1);
        chk("run_start_pulses", st_cnt - s0, 32'd1);
        chk("run_seed_at_start", 32'(co_cap), 32'(seed));
        chk("run_core_co_hold", 32'(core_co), 32'(seed));
        chk("run_status", d, 32'h0002_0001);
        wb_read(A_STEPS, d);
        chk("run_steps", d, exp_steps);
        wb_read(A_PEAK, d);
        chk("run_peak", d, 32'(exp_peak));
        wb_read(A_CTRL, d);
        chk("run_ctrl", d, {14'd0, 2'b10, seed});
        chk("run_irq", 32'(irq), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_vec_t     rst_tab[4];
        run_vec_t    runs[3];
        logic [31:0] d, s0;
        int          lat;

        rst_tab[0] = '{A_CTRL,   32'h0};
        rst_tab[1] = '{A_STATUS, 32'h0};
        rst_tab[2] = '{A_STEPS,  32'h0};
        rst_tab[3] = '{A_PEAK,   32'h0};
        runs[0] = '{16'd6,  32'd8,   16'd16};
        runs[1] = '{16'd27, 32'd111, 16'd9232};
        runs[2] = '{16'd7,  32'd16,  16'd52};

        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat_w = 32'h0;
        force_bs = 1'b0; model_en = 1'b1; model_rst = 1'b1; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_dat", dat_r, 32'h0);
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_start", 32'(core_st), 32'd0);
        chk("reset_seed_out", 32'(core_co), 32'd0);
        rst = 1'b0; model_rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            wb_read(rst_tab[i].adr, d);
            chk($sformatf("reset_reg%0d", i), d, rst_tab[i].exp);
        end
        @(posedge clk); #1;
        chk("dat_zero_outside_ack", dat_r, 32'h0);

        wb_xfer(32'h3000_0010, 1'b0, 32'h0, 4'hF, d, lat);
        chk("nonhit_no_ack", 32'(lat), 32'd0);

        for (int i = 0; i < 3; i++) begin
            do_run(runs[i].seed, runs[i].steps, runs[i].peak);
        end

        // DONE clear; interrupt follows one cycle later
        wb_write(A_STATUS, 32'h0002_0000);
        chk("clr_irq_still_high", 32'(irq), 32'd1);
        @(posedge clk); #1;
        chk("clr_irq_dropped", 32'(irq), 32'd0);
        wb_read(A_STATUS, d);
        chk("clr_status", d, 32'h0000_0001);

        // rejected launches
        force_bs = 1'b1;
        s0 = st_cnt;
        wb_write(A_CTRL, 32'h0003_0005);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_go_no_start", st_cnt, s0);
        wb_read(A_STATUS, d);
        chk("busy_go_err", d, 32'h0005_0001);
        force_bs = 1'b0;
        wb_write(A_STATUS, 32'h0004_0000);
        wb_read(A_STATUS, d);
        chk("err_cleared", d, 32'h0000_0001);
        wb_write(A_CTRL, 32'h0003_0000);
        wb_read(A_STATUS, d);
        chk("zero_seed_err", d, 32'h0004_0001);
        chk("zero_seed_no_start", st_cnt, s0);
        wb_write(A_STATUS, 32'h0004_0000);
        wb_xfer(A_CTRL, 1'b1, 32'h0001_0009, 4'h3, d, lat);
        chk("partial_sel_acked", 32'(lat), 32'd1);
        wb_read(A_CTRL, d);
        chk("partial_sel_ctrl", d, 32'h0002_0000);
        wb_read(A_STATUS, d);
        chk("partial_sel_status", d, 32'h0000_0001);
        chk("partial_sel_no_start", st_cnt, s0);

        // start timeout: busy never rises
        model_en = 1'b0;
        wb_write(A_CTRL, 32'h0003_0005);
        wb_read(A_STATUS, d);
        chk("tmo_wait_first", d, 32'h0010_0001);
        @(posedge clk);
        wb_read(A_STATUS, d);
        chk("tmo_wait_fourth", d, 32'h0010_0001);
        wb_read(A_STATUS, d);
        chk("tmo_err_idle", d, 32'h0004_0001);
        chk("tmo_one_start", st_cnt, s0 + 32'd1);
        model_en = 1'b1;
        wb_write(A_STATUS, 32'h0004_0000);
        do_run(16'd7, 32'd16, 16'd52);

        // reset in the middle of a run
        s0 = st_cnt;
        wb_write(A_CTRL, 32'h0003_001B);
        repeat (30) @(posedge clk);
        wb_read(A_STATUS, d);
        chk("mid_in_run", d & 32'h0018_0000, 32'h0018_0000);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_irq", 32'(irq), 32'd0);
        chk("mid_rst_seed_out", 32'(core_co), 32'd0);
        wb_read(A_CTRL, d);
        chk("mid_rst_ctrl", d, 32'h0);
        wb_read(A_STATUS, d);
        chk("mid_rst_status", d & 32'h001E_0000, 32'h0);
        wb_read(A_STEPS, d);
        chk("mid_rst_steps", d, 32'h0);
        wb_read(A_PEAK, d);
        chk("mid_rst_peak", d, 32'h0);
        wb_write(A_CTRL, 32'h0003_0007);
        wb_read(A_STATUS, d);
        chk("mid_busy_go_err", d & 32'h001F_0000, 32'h0005_0000);
        chk("mid_busy_no_start", st_cnt, s0 + 32'd1);
        lat = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (!core_bs) begin
                lat = 1;
                break;
            end
        end
        chk("mid_busy_fell", 32'(lat), 32'd1);
        wb_write(A_STATUS, 32'h0004_0000);
        do_run(16'd7, 32'd16, 16'd52);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
